// File: rtl/mode_counter.sv
// Loadable up/down counter with wrap, saturate, one-shot and hold modes.
// Counts 0..MODULUS-1 and raises a terminal-count pulse, a sticky overflow flag and a one-shot done flag.
module mode_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             up,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             done
);

    if (WIDTH < 2 || MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_param_check
        $fatal(1, "mode_counter: illegal WIDTH/MODULUS combination");
    end

    localparam logic [WIDTH-1:0] MAXV    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    localparam logic [1:0] MODE_WRAP = 2'b00;
    localparam logic [1:0] MODE_SAT  = 2'b01;
    localparam logic [1:0] MODE_ONE  = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    typedef enum logic {
        RUN,
        DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] cnt_q;
    logic             tc_q;
    logic             ovf_q;

    logic [WIDTH-1:0] cnt_d;
    logic             step_tc;
    logic             step_ovf;
    logic             step_done;
    logic             at_term;
    logic [WIDTH-1:0] moved;
    logic             moved_term;

    // Out-of-range load values are pinned to the top of the count range.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] value);
        if ({1'b0, value} < MOD_EXT) begin
            return value;
        end
        return MAXV;
    endfunction

    always_comb begin
        at_term    = up ? (cnt_q == MAXV) : (cnt_q == '0);
        moved      = up ? (cnt_q + 1'b1) : (cnt_q - 1'b1);
        moved_term = up ? (moved == MAXV) : (moved == '0);
        cnt_d      = cnt_q;
        step_tc    = 1'b0;
        step_ovf   = 1'b0;
        step_done  = 1'b0;
        unique case (mode)
            MODE_WRAP: begin
                if (at_term) begin
                    // The wrap lands on the opposite terminal, which also counts as terminal.
                    cnt_d    = up ? '0 : MAXV;
                    step_tc  = 1'b1;
                    step_ovf = 1'b1;
                end else begin
                    cnt_d   = moved;
                    step_tc = moved_term;
                end
            end
            MODE_SAT: begin
                if (at_term) begin
                    step_ovf = 1'b1;
                end else begin
                    cnt_d   = moved;
                    step_tc = moved_term;
                end
            end
            MODE_ONE: begin
                if (at_term) begin
                    step_ovf  = 1'b1;
                    step_done = 1'b1;
                end else begin
                    cnt_d     = moved;
                    step_tc   = moved_term;
                    step_done = moved_term;
                end
            end
            MODE_HOLD: begin
                cnt_d = cnt_q;
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (load) begin
            state_q <= RUN;
            cnt_q   <= clamp_load(din);
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (en && state_q == RUN) begin
                cnt_q <= cnt_d;
                tc_q  <= step_tc;
                if (step_ovf) begin
                    ovf_q <= 1'b1;
                end
                if (step_done) begin
                    state_q <= DONE;
                end
            end
        end
    end

    assign q    = cnt_q;
    assign tc   = tc_q;
    assign ovf  = ovf_q;
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_mode_counter.sv
// Directed bench for mode_counter (WIDTH 4, MODULUS 10) with hand-computed expectations.
module tb_mode_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic       up = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [3:0] din = 4'd0;
    logic [3:0] q;
    logic       tc;
    logic       ovf;
    logic       done;

    int checks = 0;
    int errors = 0;

    mode_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .load(load),
        .up  (up),
        .mode(mode),
        .din (din),
        .q   (q),
        .tc  (tc),
        .ovf (ovf),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input int eq, input int etc, input int eovf, input int edone);
        check({tag, ".q"}, int'(q), eq);
        check({tag, ".tc"}, int'(tc), etc);
        check({tag, ".ovf"}, int'(ovf), eovf);
        check({tag, ".done"}, int'(done), edone);
    endtask

    task automatic do_load(input logic [3:0] value);
        load = 1'b1;
        din  = value;
        tick();
        load = 1'b0;
    endtask

    int exp_q;
    int sat_q[4]   = '{1, 0, 0, 0};
    int sat_tc[4]  = '{0, 1, 0, 0};
    int sat_ovf[4] = '{0, 0, 1, 1};

    initial begin
        // Reset state
        rst = 1'b1;
        en  = 1'b1;
        tick();
        rst = 1'b0;
        en  = 1'b0;
        expect_all("reset", 0, 0, 0, 0);

        // Wrap counting up across the modulus
        mode = 2'b00;
        up   = 1'b1;
        en   = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp_q = i % 10;
            expect_all($sformatf("wrap%0d", i), exp_q, (exp_q == 9 || exp_q == 0) ? 1 : 0,
                       (i >= 10) ? 1 : 0, 0);
        end

        // Saturate down; the load must also clear the sticky ovf from the wrap
        en = 1'b0;
        do_load(4'd2);
        expect_all("satload", 2, 0, 0, 0);
        mode = 2'b01;
        up   = 1'b0;
        en   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_all($sformatf("sat%0d", i), sat_q[i], sat_tc[i], sat_ovf[i], 0);
        end

        // One-shot up from 7, then a reload leaves DONE
        en = 1'b0;
        do_load(4'd7);
        mode = 2'b10;
        up   = 1'b1;
        en   = 1'b1;
        tick();
        expect_all("os8", 8, 0, 0, 0);
        tick();
        expect_all("os9", 9, 1, 0, 1);
        tick();
        expect_all("oshold1", 9, 0, 0, 1);
        tick();
        expect_all("oshold2", 9, 0, 0, 1);
        do_load(4'd3);
        expect_all("osreload", 3, 0, 0, 0);

        // One-shot loaded at the terminal: done and ovf without moving
        en = 1'b0;
        do_load(4'd9);
        en = 1'b1;
        tick();
        expect_all("osatT", 9, 0, 1, 1);

        // Wrap step sets ovf/tc, then load with en and an out-of-range din clamps and clears
        mode = 2'b00;
        en   = 1'b0;
        do_load(4'd9);
        en = 1'b1;
        tick();
        expect_all("wrapup", 0, 1, 1, 0);
        load = 1'b1;
        din  = 4'd15;
        tick();
        load = 1'b0;
        en   = 1'b0;
        expect_all("clamp", 9, 0, 0, 0);

        // Wrap down from 0
        do_load(4'd0);
        up = 1'b0;
        en = 1'b1;
        tick();
        expect_all("wrapdn", 9, 1, 1, 0);
        en = 1'b0;
        tick();
        expect_all("idle", 9, 0, 1, 0);

        // Hold mode, then reset during en wins
        do_load(4'd5);
        mode = 2'b11;
        en   = 1'b1;
        tick();
        expect_all("hold1", 5, 0, 0, 0);
        tick();
        expect_all("hold2", 5, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_all("rstmid", 0, 0, 0, 0);

        // Reset in DONE wins over simultaneous load and en
        en = 1'b0;
        do_load(4'd8);
        mode = 2'b10;
        up   = 1'b1;
        en   = 1'b1;
        tick();
        expect_all("predone", 9, 1, 0, 1);
        rst  = 1'b1;
        load = 1'b1;
        din  = 4'd4;
        tick();
        rst  = 1'b0;
        load = 1'b0;
        expect_all("rstdone", 0, 0, 0, 0);

        // Direction change mid-count
        mode = 2'b00;
        up   = 1'b1;
        en   = 1'b0;
        do_load(4'd3);
        en = 1'b1;
        tick();
        expect_all("dirup", 4, 0, 0, 0);
        up = 1'b0;
        tick();
        expect_all("dirdn", 3, 0, 0, 0);
        en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mode_counter.md
# mode_counter

Parametrised, loadable up/down counter with selectable run mode (wrap, saturate, one-shot, hold), programmable modulus, terminal-count pulse and sticky overflow flag. It is the generalised successor of the chapter-3 fixed-width control/data counter example. It serves as the reusable timing and sequencing element for later chapter examples: dividers, timeouts and event counters.

## Interface
Parameters:
- WIDTH, 4, counter and load-data width in bits (≥ 2)
- MODULUS, 10, count range 0..MODULUS-1; legal 2 ≤ MODULUS ≤ 2**WIDTH (elaboration-time check, fatal otherwise)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  one clock; reset is synchronous and active-high
- en  input  1  count enable, one step per enabled cycle
- load  input  1  synchronous load of din
- up  input  1  direction: 1 = increment, 0 = decrement
- mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 hold
- din  input  WIDTH  load value
- q  output  WIDTH  current count (registered)
- tc  output  1  terminal-count pulse (registered, one cycle)
- ovf  output  1  sticky overflow/underflow flag
- done  output  1  one-shot complete (FSM in DONE)

## Operation
- Priority per edge: rst > load > en. When en=0 and load=0, q holds.
- Terminal value T: MODULUS-1 when up=1, 0 when up=0.
- Load: q ← din if din < MODULUS, else q ← MODULUS-1 (clamp). Load clears ovf, tc and done, and returns the FSM to RUN.
- FSM states: RUN, DONE.
  - RUN → DONE only in mode 10, on an enabled step whose next q equals T.
  - DONE → RUN only on load or rst.
  - In DONE, en is ignored and q holds.
- Enabled step in RUN, by mode:
  - 00 wrap: up at MODULUS-1 → 0; down at 0 → MODULUS-1. The wrap step sets ovf. Otherwise q ± 1.
  - 01 saturate: a step beyond T leaves q at T and sets ovf. Otherwise q ± 1.
  - 10 one-shot: q ± 1 toward T. Reaching T enters DONE. An en step while q already equals T (e.g. loaded at T) enters DONE without moving q and sets ovf.
  - 11 hold: q unchanged, no flag changes.
- tc = 1 for exactly the cycle after an enabled step whose resulting q equals T. A wrap step also raises tc, because the resulting q equals the opposite-direction terminal. Concretely, tc is high when a step in wrap mode lands on 0 (up) or MODULUS-1 (down). Loads never raise tc.
- ovf remains set until rst or load.
- Changing up or mode takes effect on the next edge; the current q is not altered. In mode 01 or 10, a q value already beyond T cannot occur.

## Timing
- Reset values: q = 0, tc = 0, ovf = 0, done = 0, FSM = RUN.
- Latency: one cycle from the en/load sample edge to q, tc, ovf and done; all outputs are registered.
- rst asserted mid-count or in DONE wins on that edge, regardless of load or en.
- Simultaneous load and en: load wins and en is discarded for that cycle.
- Back-to-back en: one step per cycle, no bubbles. Wrap is seamless (…8, 9, 0, 1…).
- done follows the FSM state and updates on the same edge as q.

## Test plan
- Reset then wrap: rst 1 cycle, mode=00, up=1, en=1 for 12 cycles (WIDTH 4, MODULUS 10). Required:
  - q = 1..9, 0, 1, 2
  - tc high in the cycle q=9, and again when q=0 after the wrap
  - ovf = 1 from the wrap cycle onward
- Saturate down: load din=2, mode=01, up=0, en for 4 cycles. Required:
  - q = 1, 0, 0, 0
  - tc pulses once, at the first q=0
  - ovf = 1 after the third step
- One-shot: load 7, mode=10, up=1, en held high. Required:
  - q = 8, 9, then holds 9
  - done = 1 from the cycle q=9
  - a load of 3 clears done and q=3 on the next cycle
- Load clamp and priority: load=1, en=1, din=15 → q=9, tc=0, ovf cleared.
- Hold and mid-operation reset: mode=11 with en=1 keeps q=5. Then rst during en=1 → q=0 and all flags 0 on the next edge.
- Direction change: counting up at q=4, set up=0 → the next step gives q=3, with no tc or ovf.
